// File: rtl/reg_file_mp.sv
// Multi-port architectural register file with same-cycle write bypass and a per-register
// busy scoreboard for issue-time hazard detection. x0 reads as zero and is never busy.
module reg_file_mp #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_READ      = 4,
  parameter int unsigned NUM_WRITE     = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]     rd_data,
  output logic [NUM_READ-1:0]                rd_busy,
  input  logic [NUM_WRITE-1:0]               wr_en,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]    wr_data,
  input  logic [NUM_WRITE-1:0]               alloc_en,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] alloc_addr,
  output logic [DATA_WIDTH-1:0]              a0
);

  localparam int unsigned NumRegs = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] A0Idx = ADDRESS_WIDTH'(10);

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [DATA_WIDTH-1:0] regs_d [NumRegs];
  logic [NumRegs-1:0]    busy_q, busy_d;

  // Ports are walked in program order so the youngest write to an address lands last.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned j = 0; j < NUM_WRITE; j++) begin
      if (wr_en[j] && (wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0)) begin
        regs_d[wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    regs_d[0] = '0;
  end

  // Clears are applied before sets so a same-cycle allocation keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned j = 0; j < NUM_WRITE; j++) begin
      if (wr_en[j]) begin
        busy_d[wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b0;
      end
    end
    for (int unsigned k = 0; k < NUM_WRITE; k++) begin
      if (alloc_en[k]) begin
        busy_d[alloc_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
    logic                     busy;

    assign addr = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    always_comb begin
      data = regs_q[addr];
      busy = busy_q[addr];
      for (int unsigned j = 0; j < NUM_WRITE; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] == addr)) begin
          data = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
          busy = 1'b0;
        end
      end
      if (addr == '0) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_busy[i]                          = busy;
  end

  // Stored value only: no bypass, so it trails a write by one cycle.
  assign a0 = regs_q[A0Idx];

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus a randomized full-port run
// compared against an array-based reference model.
module tb_reg_file_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NW-1:0]    alloc_en;
  logic [NW*AW-1:0] alloc_addr;
  logic [DW-1:0]    a0;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] m_regs [32];
  logic          m_busy [32];

  reg_file_mp #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .NUM_READ     (NR),
    .NUM_WRITE    (NW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .a0        (a0)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = '0; alloc_addr = '0; rd_addr = '0;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = a;
    wr_data[j*DW +: DW] = d;
  endtask

  task automatic set_alloc(input int k, input logic [AW-1:0] a);
    alloc_en[k] = 1'b1;
    alloc_addr[k*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rd_port(input int i);
    return rd_data[i*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Architectural view: what each register holds after this edge.
  function automatic logic [DW-1:0] next_value(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = m_regs[a];
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*DW +: DW];
    return (a == 0) ? '0 : v;
  endfunction

  function automatic bit written_now(input logic [AW-1:0] a);
    bit w;
    w = 1'b0;
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) w = 1'b1;
    return w;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    return (a != 0) && m_busy[a] && !written_now(a);
  endfunction

  // A read sees the post-write value whenever the register is written this cycle.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return written_now(a) ? next_value(a) : ((a == 0) ? '0 : m_regs[a]);
  endfunction

  task automatic model_step();
    logic [DW-1:0] nv [32];
    bit            nb [32];
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int r = 0; r < 32; r++) begin
      nv[r] = next_value(AW'(r));
      nb[r] = m_busy[r] && !written_now(AW'(r));
    end
    for (int k = 0; k < NW; k++)
      if (alloc_en[k]) nb[alloc_addr[k*AW +: AW]] = 1'b1;
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = nv[r];
      m_busy[r] = (r != 0) && nb[r];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    set_wr(0, 5'd5, 32'h1234);
    set_alloc(0, 5'd12);
    tick();
    set_idle();
    set_rd(0, 5'd5);
    set_rd(1, 5'd12);
    #1;
    n_total++;
    if (rd_port(0) !== 32'h1234) $display("FAIL reset_pre_x5 got %h want %h", rd_port(0), 32'h1234);
    else n_pass++;
    n_total++;
    if (rd_busy[1] !== 1'b1) $display("FAIL reset_pre_busy12 got %b want 1", rd_busy[1]);
    else n_pass++;
    // Reset lands while a write to x6 is pending; that write must be lost.
    set_wr(0, 5'd6, 32'hABCD);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (rd_port(0) !== '0) $display("FAIL reset_async_x5 got %h want 0", rd_port(0));
    else n_pass++;
    n_total++;
    if (a0 !== '0) $display("FAIL reset_async_a0 got %h want 0", a0);
    else n_pass++;
    tick();
    set_idle();
    rst_n = 1'b1;
    set_rd(0, 5'd5);
    set_rd(1, 5'd12);
    set_rd(2, 5'd6);
    #1;
    n_total++;
    if (rd_port(0) !== '0) $display("FAIL reset_x5 got %h want 0", rd_port(0));
    else n_pass++;
    n_total++;
    if (rd_port(2) !== '0) $display("FAIL reset_x6_discarded got %h want 0", rd_port(2));
    else n_pass++;
    n_total++;
    if (rd_busy !== '0) $display("FAIL reset_busy got %b want 0000", rd_busy);
    else n_pass++;
    n_total++;
    if (a0 !== '0) $display("FAIL reset_a0 got %h want 0", a0);
    else n_pass++;
    set_wr(0, 5'd0, 32'hFFFF_FFFF);
    set_wr(1, 5'd0, 32'hFFFF_FFFF);
    set_alloc(0, 5'd0);
    set_rd(3, 5'd0);
    #1;
    n_total++;
    if (rd_port(3) !== '0) $display("FAIL x0_bypass got %h want 0", rd_port(3));
    else n_pass++;
    tick();
    set_idle();
    set_rd(3, 5'd0);
    #1;
    n_total++;
    if (rd_port(3) !== '0 || rd_busy[3] !== 1'b0)
      $display("FAIL x0_stored got %h/%b want 0/0", rd_port(3), rd_busy[3]);
    else n_pass++;
  endtask

  task automatic test_bypass();
    set_idle();
    set_wr(0, 5'd7, 32'hDEAD_BEEF);
    set_rd(2, 5'd7);
    #1;
    n_total++;
    if (rd_port(2) !== 32'hDEAD_BEEF) $display("FAIL bypass_same got %h want deadbeef", rd_port(2));
    else n_pass++;
    tick();
    set_idle();
    set_rd(2, 5'd7);
    #1;
    n_total++;
    if (rd_port(2) !== 32'hDEAD_BEEF) $display("FAIL bypass_next got %h want deadbeef", rd_port(2));
    else n_pass++;
  endtask

  task automatic test_collision();
    set_idle();
    set_wr(0, 5'd3, 32'h11);
    set_wr(1, 5'd3, 32'h22);
    set_rd(0, 5'd3);
    #1;
    n_total++;
    if (rd_port(0) !== 32'h22) $display("FAIL collision_same got %h want 22", rd_port(0));
    else n_pass++;
    tick();
    set_idle();
    set_rd(0, 5'd3);
    #1;
    n_total++;
    if (rd_port(0) !== 32'h22) $display("FAIL collision_next got %h want 22", rd_port(0));
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    set_idle();
    set_alloc(1, 5'd9);
    tick();
    set_idle();
    set_rd(1, 5'd9);
    #1;
    n_total++;
    if (rd_busy[1] !== 1'b1) $display("FAIL sb_alloc got %b want 1", rd_busy[1]);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (rd_busy[1] !== 1'b1) $display("FAIL sb_hold got %b want 1", rd_busy[1]);
    else n_pass++;
    set_wr(1, 5'd9, 32'h99);
    #1;
    n_total++;
    if (rd_busy[1] !== 1'b0) $display("FAIL sb_clear_bypass got %b want 0", rd_busy[1]);
    else n_pass++;
    tick();
    set_idle();
    set_rd(1, 5'd9);
    #1;
    n_total++;
    if (rd_busy[1] !== 1'b0) $display("FAIL sb_cleared got %b want 0", rd_busy[1]);
    else n_pass++;
    set_wr(0, 5'd9, 32'h98);
    set_alloc(1, 5'd9);
    tick();
    set_idle();
    set_rd(1, 5'd9);
    #1;
    n_total++;
    if (rd_busy[1] !== 1'b1) $display("FAIL sb_set_wins got %b want 1", rd_busy[1]);
    else n_pass++;
  endtask

  task automatic test_a0();
    set_idle();
    set_wr(1, 5'd10, 32'h2A);
    set_rd(1, 5'd10);
    #1;
    n_total++;
    if (a0 !== 32'h0) $display("FAIL a0_lag got %h want 0", a0);
    else n_pass++;
    n_total++;
    if (rd_port(1) !== 32'h2A) $display("FAIL a0_rd_bypass got %h want 2a", rd_port(1));
    else n_pass++;
    tick();
    set_idle();
    #1;
    n_total++;
    if (a0 !== 32'h2A) $display("FAIL a0_next got %h want 2a", a0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [AW-1:0] w [NW];
    logic [AW-1:0] a;
    for (int c = 0; c < 100; c++) begin
      set_idle();
      w[0] = AW'($urandom_range(1, 31));
      do w[1] = AW'($urandom_range(1, 31)); while (w[1] == w[0]);
      for (int j = 0; j < NW; j++) begin
        if ($urandom_range(0, 7) != 0) set_wr(j, w[j], $urandom);
        if ($urandom_range(0, 2) == 0) set_alloc(j, AW'($urandom_range(0, 31)));
      end
      for (int i = 0; i < NR; i++) begin
        a = ($urandom_range(0, 1) == 0) ? w[$urandom_range(0, 1)] : AW'($urandom_range(0, 31));
        set_rd(i, a);
      end
      #1;
      for (int i = 0; i < NR; i++) begin
        a = rd_addr[i*AW +: AW];
        n_total++;
        if (rd_port(i) !== exp_rd(a))
          $display("FAIL rand_data c%0d p%0d x%0d got %h want %h", c, i, a, rd_port(i), exp_rd(a));
        else n_pass++;
        n_total++;
        if (rd_busy[i] !== exp_busy(a))
          $display("FAIL rand_busy c%0d p%0d x%0d got %b want %b", c, i, a, rd_busy[i], exp_busy(a));
        else n_pass++;
      end
      n_total++;
      if (a0 !== m_regs[10]) $display("FAIL rand_a0 c%0d got %h want %h", c, a0, m_regs[10]);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    set_idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_a0();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
